// File: rtl/temporizador_segundos.sv
// Elapsed-seconds counter fed by the 1 Hz tick divider: counts 0..LIMITE in BCD
// under start/pause/clear control and pulses Fim when LIMITE is reached.
module temporizador_segundos #(
    parameter int LIMITE = 20
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Tempo,
    input  logic       Iniciar,
    input  logic       Pausar,
    input  logic       Limpar,
    output logic [3:0] Seg_Dezena,
    output logic [3:0] Seg_Unidade,
    output logic       Contando,
    output logic       Fim,
    output logic [1:0] Estado
);

    if (LIMITE < 1 || LIMITE > 99) begin : g_limite_invalido
        $error("LIMITE must be within 1..99");
    end

    typedef enum logic [1:0] {
        S_OCIOSO   = 2'b00,
        S_CONTANDO = 2'b01,
        S_PAUSADO  = 2'b10,
        S_FIM      = 2'b11
    } estado_t;

    // Count value that the terminal tick turns into LIMITE, split into BCD digits.
    localparam logic [3:0] TERM_DEZ = 4'((LIMITE - 1) / 10);
    localparam logic [3:0] TERM_UNI = 4'((LIMITE - 1) % 10);
    localparam logic [3:0] LIM_DEZ  = 4'(LIMITE / 10);
    localparam logic [3:0] LIM_UNI  = 4'(LIMITE % 10);

    estado_t    estado, prox_estado;
    logic [3:0] dezena, prox_dezena;
    logic [3:0] unidade, prox_unidade;
    logic       fim_q, prox_fim;
    logic       iniciar_q, pausar_q;
    logic       ini_ev, pau_ev;

    assign ini_ev = Iniciar & ~iniciar_q;
    assign pau_ev = Pausar & ~pausar_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            estado    <= S_OCIOSO;
            dezena    <= 4'd0;
            unidade   <= 4'd0;
            fim_q     <= 1'b0;
            iniciar_q <= 1'b0;
            pausar_q  <= 1'b0;
        end else begin
            estado    <= prox_estado;
            dezena    <= prox_dezena;
            unidade   <= prox_unidade;
            fim_q     <= prox_fim;
            iniciar_q <= Iniciar;
            pausar_q  <= Pausar;
        end
    end

    // Priority Limpar > pau_ev > ini_ev > Tempo; a consumed event drops the tick.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal (no latches).
        prox_estado  = estado;
        prox_dezena  = dezena;
        prox_unidade = unidade;
        prox_fim     = 1'b0;
        if (Limpar) begin
            prox_estado  = S_OCIOSO;
            prox_dezena  = 4'd0;
            prox_unidade = 4'd0;
        end else if (pau_ev) begin
            if (estado == S_CONTANDO) prox_estado = S_PAUSADO;
        end else if (ini_ev && estado != S_CONTANDO) begin
            prox_estado = S_CONTANDO;
            if (estado == S_FIM) begin
                prox_dezena  = 4'd0;
                prox_unidade = 4'd0;
            end
        end else if (Tempo && estado == S_CONTANDO) begin
            if (dezena == TERM_DEZ && unidade == TERM_UNI) begin
                prox_dezena  = LIM_DEZ;
                prox_unidade = LIM_UNI;
                prox_estado  = S_FIM;
                prox_fim     = 1'b1;
            end else if (unidade == 4'd9) begin
                prox_unidade = 4'd0;
                prox_dezena  = dezena + 4'd1;
            end else begin
                prox_unidade = unidade + 4'd1;
            end
        end
    end

    always_comb begin
        Estado      = estado;
        Contando    = (estado == S_CONTANDO);
        Fim         = fim_q;
        Seg_Dezena  = dezena;
        Seg_Unidade = unidade;
    end

endmodule

// File: tb/tb_temporizador_segundos.sv
// Directed bench for temporizador_segundos: LIMITE=20 main instance plus a
// LIMITE=1 instance for the single-second boundary.
module tb_temporizador_segundos;

    logic       CLK = 1'b0;
    logic       RST, Tempo, Iniciar, Pausar, Limpar;
    logic [3:0] Seg_Dezena, Seg_Unidade;
    logic       Contando, Fim;
    logic [1:0] Estado;

    logic       rst1, tempo1, iniciar1, pausar1, limpar1;
    logic [3:0] dez1, uni1;
    logic       contando1, fim1;
    logic [1:0] estado1;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    temporizador_segundos #(.LIMITE(20)) dut (
        .CLK(CLK), .RST(RST), .Tempo(Tempo), .Iniciar(Iniciar), .Pausar(Pausar),
        .Limpar(Limpar), .Seg_Dezena(Seg_Dezena), .Seg_Unidade(Seg_Unidade),
        .Contando(Contando), .Fim(Fim), .Estado(Estado)
    );

    temporizador_segundos #(.LIMITE(1)) dut1 (
        .CLK(CLK), .RST(rst1), .Tempo(tempo1), .Iniciar(iniciar1), .Pausar(pausar1),
        .Limpar(limpar1), .Seg_Dezena(dez1), .Seg_Unidade(uni1),
        .Contando(contando1), .Fim(fim1), .Estado(estado1)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge, inputs change there too.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic tick();
        Tempo = 1'b1;
        step();
        Tempo = 1'b0;
    endtask

    task automatic start();
        Iniciar = 1'b1;
        step();
        Iniciar = 1'b0;
    endtask

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        RST = 1'b1; Tempo = 1'b0; Iniciar = 1'b0; Pausar = 1'b0; Limpar = 1'b0;
        rst1 = 1'b1; tempo1 = 1'b0; iniciar1 = 1'b1; pausar1 = 1'b0; limpar1 = 1'b0;

        // 1: reset held 3 cycles
        repeat (3) step();
        RST = 1'b0;
        rst1 = 1'b0;
        check("rst_estado", {6'd0, Estado}, 8'h00);
        check("rst_digits", {Seg_Dezena, Seg_Unidade}, 8'h00);
        check("rst_fim", {7'd0, Fim}, 8'h00);
        check("rst_contando", {7'd0, Contando}, 8'h00);
        step();
        // LIMITE=1 instance: Iniciar held through reset starts on first cycle
        check("lvl_start_estado1", {6'd0, estado1}, 8'h01);
        iniciar1 = 1'b0;
        check("idle_estado", {6'd0, Estado}, 8'h00);

        // 2: full count to LIMITE
        start();
        check("start_estado", {6'd0, Estado}, 8'h01);
        check("start_contando", {7'd0, Contando}, 8'h01);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check($sformatf("count_%0d", k), {Seg_Dezena, Seg_Unidade}, bcd(k));
            check($sformatf("fim_at_%0d", k), {7'd0, Fim}, (k == 20) ? 8'h01 : 8'h00);
            if (k == 20) check("fim_estado", {6'd0, Estado}, 8'h03);
            repeat (4) step();
        end
        check("fim_one_cycle", {7'd0, Fim}, 8'h00);
        repeat (3) begin
            tick();
            repeat (4) step();
        end
        check("fim_hold_digits", {Seg_Dezena, Seg_Unidade}, 8'h20);
        check("fim_hold_estado", {6'd0, Estado}, 8'h03);
        check("fim_no_repulse", {7'd0, Fim}, 8'h00);

        // 3: pause with coincident tick, resume with coincident tick
        Limpar = 1'b1;
        step();
        Limpar = 1'b0;
        check("clr_digits", {Seg_Dezena, Seg_Unidade}, 8'h00);
        start();
        repeat (7) tick();
        check("pre_pause", {Seg_Dezena, Seg_Unidade}, 8'h07);
        Pausar = 1'b1; Tempo = 1'b1;
        step();
        Pausar = 1'b0; Tempo = 1'b0;
        check("pause_digits", {Seg_Dezena, Seg_Unidade}, 8'h07);
        check("pause_estado", {6'd0, Estado}, 8'h02);
        check("pause_contando", {7'd0, Contando}, 8'h00);
        repeat (4) tick();
        check("paused_ticks", {Seg_Dezena, Seg_Unidade}, 8'h07);
        Iniciar = 1'b1; Tempo = 1'b1;
        step();
        Iniciar = 1'b0; Tempo = 1'b0;
        check("resume_digits", {Seg_Dezena, Seg_Unidade}, 8'h07);
        check("resume_estado", {6'd0, Estado}, 8'h01);
        tick();
        check("resume_tick", {Seg_Dezena, Seg_Unidade}, 8'h08);

        // 4: clear beats tick and start; held Iniciar gives no new start
        repeat (7) tick();
        check("pre_clear", {Seg_Dezena, Seg_Unidade}, 8'h15);
        Limpar = 1'b1; Tempo = 1'b1; Iniciar = 1'b1;
        step();
        Limpar = 1'b0; Tempo = 1'b0;
        check("clear_digits", {Seg_Dezena, Seg_Unidade}, 8'h00);
        check("clear_estado", {6'd0, Estado}, 8'h00);
        check("clear_fim", {7'd0, Fim}, 8'h00);
        step();
        tick();
        step();
        check("held_ini_estado", {6'd0, Estado}, 8'h00);
        check("held_ini_digits", {Seg_Dezena, Seg_Unidade}, 8'h00);
        Iniciar = 1'b0;
        step();

        // 5: LIMITE=1 instance, already counting
        tempo1 = 1'b1;
        step();
        tempo1 = 1'b0;
        check("l1_digits", {dez1, uni1}, 8'h01);
        check("l1_fim", {7'd0, fim1}, 8'h01);
        check("l1_estado", {6'd0, estado1}, 8'h03);
        step();
        check("l1_fim_width", {7'd0, fim1}, 8'h00);
        check("l1_contando", {7'd0, contando1}, 8'h00);
        iniciar1 = 1'b1;
        step();
        iniciar1 = 1'b0;
        check("l1_restart_digits", {dez1, uni1}, 8'h00);
        check("l1_restart_estado", {6'd0, estado1}, 8'h01);

        // 6: reset mid-count with a tick in the same cycle
        start();
        repeat (12) tick();
        check("pre_rst", {Seg_Dezena, Seg_Unidade}, 8'h12);
        RST = 1'b1; Tempo = 1'b1;
        step();
        RST = 1'b0; Tempo = 1'b0;
        check("midrst_digits", {Seg_Dezena, Seg_Unidade}, 8'h00);
        check("midrst_estado", {6'd0, Estado}, 8'h00);
        check("midrst_fim", {7'd0, Fim}, 8'h00);
        check("midrst_contando", {7'd0, Contando}, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
